sq_register_gen: RTL
====================

Name: sq_register_gen

Overview:
- Parametrised sequence-register block: latches the next-instruction opcode fields from the write bus at end of each instruction (T12 with NISQ).
- Tracks the pending extend (FUTEXT/SQEXT), INHINT and interrupt-in-progress (IIP) state.
- Forces a RUPT instruction load when an enabled interrupt is pending, arbitrating among RUPT_CH request channels. Multi-channel arbitration and the vector output are new relative to the fixed single-rupt SQ logic.
- Sits between the write bus/timing-pulse generator and the crosspoint/stage decode logic; drives the one-hot opcode decode consumed there.

Parameters:
- WW, 16, write-bus width.
- OPW, 3, opcode field width (SQ); taken from WL[WW-1 -: OPW].
- RUPT_CH, 4, number of interrupt request channels (1..16).
- RUPT_SQ, 3'b000, SQ value forced on an interrupt load.
- RUPT_QC, 2'b00, QC value forced on an interrupt load.
- RUPT_SQR10, 1'b1, SQR10 value forced on an interrupt load.

Ports:
- CLOCK  in  1  system clock; all state updates on rising edge.
- SIM_RST_n  in  1  asynchronous active-low reset.
- T12  in  1  one-CLOCK strobe marking end of memory cycle.
- NISQ  in  1  next-instruction request pulse.
- WL  in  WW  write bus.
- EXTPLS  in  1  EXTEND pulse; sets FUTEXT.
- INHPLS  in  1  sets INHINT.
- RELPLS  in  1  clears INHINT.
- KRPT  in  1  RESUME; clears IIP.
- OVNHRP  in  1  overflow rupt inhibit.
- MNHRPT  in  1  monitor rupt inhibit.
- RUPT_REQ  in  RUPT_CH  level interrupt requests; bit 0 has highest priority.
- SQ  out  OPW  opcode register.
- QC  out  2  quarter code.
- SQR10  out  1  WL[WW-OPW-3] latch.
- SQEXT  out  1  extended-opcode flag.
- FUTEXT  out  1  pending extend.
- INHINT  out  1  interrupt inhibit.
- IIP  out  1  interrupt in progress.
- STRTFC  out  1  start-force, high from reset until first load.
- RPTFRC  out  1  one-cycle pulse on an interrupt load.
- RUPT_ACK  out  RUPT_CH  one-hot, one-cycle acknowledge.
- RUPT_VEC  out  max(1,$clog2(RUPT_CH))  index of the last accepted channel.
- OPDEC  out  2**(OPW+1)  one-hot decode of {SQEXT,SQ}.

Behaviour:
- Reset, asynchronous: SQ=0, QC=0, SQR10=0, SQEXT=0, FUTEXT=0, INHINT=0, IIP=0, NISQL=0, STRTFC=1, RPTFRC=0, RUPT_ACK=0, RUPT_VEC=0. OPDEC=1 (bit 0).
- NISQL (internal): set on any cycle with NISQ=1. Cleared on a load cycle unless NISQ=1 in that same cycle, in which case NISQ wins.
- Load cycle = T12 & (NISQL | STRTFC). All load updates are visible on the register outputs the cycle after the load edge.
- Priority within a load cycle:
  1. STRTFC: SQ=0, QC=0, SQR10=0, SQEXT=0, FUTEXT=0, STRTFC<=0.
  2. Interrupt: taken when |RUPT_REQ & ~INHINT & ~IIP & ~FUTEXT & ~OVNHRP & ~MNHRPT.
     - SQ/QC/SQR10 <= RUPT_SQ/RUPT_QC/RUPT_SQR10; SQEXT<=0; IIP<=1.
     - RPTFRC=1 for one cycle.
     - RUPT_ACK = one-hot of the lowest set RUPT_REQ bit, for one cycle; RUPT_VEC <= that index and holds until the next accept.
  3. Normal: SQ<=WL[WW-1 -: OPW]; {QC,SQR10}<=next 3 bits down; SQEXT<=FUTEXT; FUTEXT<=0.
- EXTPLS sets FUTEXT. If EXTPLS coincides with a normal load, SQEXT takes the old FUTEXT and FUTEXT ends at 1.
- An interrupt is never taken while FUTEXT=1, so an extended instruction is never split.
- INHINT: INHPLS sets, RELPLS clears; if both are asserted, RELPLS wins. INHINT does not change on loads.
- IIP: KRPT clears it. If an interrupt load and KRPT occur in the same cycle, the set wins.
- Requests are not latched. RUPT_REQ dropping before T12 cancels the interrupt.
- OPDEC is combinational from the registered SQEXT/SQ and is always exactly one-hot.
- T12 without NISQL and without STRTFC: no register change.
- Reset asserted mid-operation clears everything immediately. The first load after release is always a STRTFC load, even if a request is pending.

Test Plan:
- Reset, then T12 with WL=16'hFFFF -> STRTFC load: SQ=0, QC=0, SQEXT=0, OPDEC=1, STRTFC=0.
- NISQ, then T12 with WL=16'b101_10_1_xxxxxxxxxx -> SQ=3'b101, QC=2'b10, SQR10=1, OPDEC bit 5.
- EXTPLS, then NISQ+T12 with WL opcode 3'b011 -> SQEXT=1, OPDEC bit 11, FUTEXT=0. Repeat with EXTPLS in the T12 cycle -> SQEXT=0, FUTEXT=1.
- RUPT_REQ=4'b1010, NISQ+T12 -> RPTFRC=1, RUPT_ACK=4'b0010, RUPT_VEC=1, IIP=1, SQ=RUPT_SQ. Second NISQ+T12 with requests still high -> normal load (IIP blocks). KRPT -> IIP=0.
- Request blocked by INHINT, then by FUTEXT, then by MNHRPT -> normal loads each time. INHPLS+RELPLS together -> INHINT=0.
- Reset asserted between NISQ and T12 -> all outputs at reset values. Next T12 -> STRTFC load, no RUPT_ACK.

Source files
------------

// File: rtl/sq_register_gen.sv
// Sequence register: latches the next-instruction opcode fields from the write
// bus at T12 of a NISQ cycle, tracks extend/inhibit/interrupt-in-progress state,
// and substitutes a RUPT instruction when an enabled interrupt request is pending.
module sq_register_gen #(
    parameter int          WW         = 16,
    parameter int          OPW        = 3,
    parameter int          RUPT_CH    = 4,
    parameter logic [OPW-1:0] RUPT_SQ = 3'b000,
    parameter logic [1:0]  RUPT_QC    = 2'b00,
    parameter logic        RUPT_SQR10 = 1'b1
) (
    input  logic                  CLOCK,
    input  logic                  SIM_RST_n,
    input  logic                  T12,
    input  logic                  NISQ,
    input  logic [WW-1:0]         WL,
    input  logic                  EXTPLS,
    input  logic                  INHPLS,
    input  logic                  RELPLS,
    input  logic                  KRPT,
    input  logic                  OVNHRP,
    input  logic                  MNHRPT,
    input  logic [RUPT_CH-1:0]    RUPT_REQ,
    output logic [OPW-1:0]        SQ,
    output logic [1:0]            QC,
    output logic                  SQR10,
    output logic                  SQEXT,
    output logic                  FUTEXT,
    output logic                  INHINT,
    output logic                  IIP,
    output logic                  STRTFC,
    output logic                  RPTFRC,
    output logic [RUPT_CH-1:0]    RUPT_ACK,
    output logic [((RUPT_CH > 1) ? $clog2(RUPT_CH) : 1)-1:0] RUPT_VEC,
    output logic [2**(OPW+1)-1:0] OPDEC
);

    localparam int VW = (RUPT_CH > 1) ? $clog2(RUPT_CH) : 1;

    logic [OPW-1:0]     sq_reg, sq_next;
    logic [1:0]         qc_reg, qc_next;
    logic               sqr10_reg, sqr10_next;
    logic               sqext_reg, sqext_next;
    logic               futext_reg, futext_next;
    logic               inhint_reg, inhint_next;
    logic               iip_reg, iip_next;
    logic               nisql_reg, nisql_next;
    logic               strtfc_reg, strtfc_next;
    logic               rptfrc_reg, rptfrc_next;
    logic [RUPT_CH-1:0] ack_reg, ack_next;
    logic [VW-1:0]      vec_reg, vec_next;

    logic               load;
    logic               rupt_take;
    logic [RUPT_CH-1:0] grant;
    logic [VW-1:0]      grant_idx;

    // Low bits of the write bus below SQR10 are not part of the sequence register.
    logic unused_wl_bits;
    assign unused_wl_bits = ^WL[WW-OPW-4:0];

    assign load      = T12 & (nisql_reg | strtfc_reg);
    // A pending extend blocks interrupts so an extended instruction is never split.
    assign rupt_take = (|RUPT_REQ) & ~inhint_reg & ~iip_reg & ~futext_reg & ~OVNHRP & ~MNHRPT;

    // Fixed-priority arbiter: scan high to low so the lowest set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = RUPT_CH - 1; i >= 0; i--) begin
            if (RUPT_REQ[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = VW'(i);
            end
        end
    end

    // Next-state logic: start-force beats interrupt, interrupt beats normal load.
    always_comb begin
        sq_next     = sq_reg;
        qc_next     = qc_reg;
        sqr10_next  = sqr10_reg;
        sqext_next  = sqext_reg;
        futext_next = futext_reg;
        inhint_next = inhint_reg;
        iip_next    = iip_reg;
        nisql_next  = nisql_reg;
        strtfc_next = strtfc_reg;
        rptfrc_next = 1'b0;
        ack_next    = '0;
        vec_next    = vec_reg;

        if (KRPT)
            iip_next = 1'b0;
        if (load)
            nisql_next = 1'b0;
        if (NISQ)
            nisql_next = 1'b1;

        if (load) begin
            if (strtfc_reg) begin
                sq_next     = '0;
                qc_next     = '0;
                sqr10_next  = 1'b0;
                sqext_next  = 1'b0;
                futext_next = 1'b0;
                strtfc_next = 1'b0;
            end else if (rupt_take) begin
                sq_next     = RUPT_SQ;
                qc_next     = RUPT_QC;
                sqr10_next  = RUPT_SQR10;
                sqext_next  = 1'b0;
                iip_next    = 1'b1;
                rptfrc_next = 1'b1;
                ack_next    = grant;
                vec_next    = grant_idx;
            end else begin
                sq_next     = WL[WW-1 -: OPW];
                qc_next     = WL[WW-OPW-1 -: 2];
                sqr10_next  = WL[WW-OPW-3];
                sqext_next  = futext_reg;
                futext_next = 1'b0;
            end
        end

        if (EXTPLS)
            futext_next = 1'b1;
        if (INHPLS)
            inhint_next = 1'b1;
        if (RELPLS)
            inhint_next = 1'b0;
    end

    // State register with asynchronous reset to the start-force state.
    always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            sq_reg     <= '0;
            qc_reg     <= '0;
            sqr10_reg  <= 1'b0;
            sqext_reg  <= 1'b0;
            futext_reg <= 1'b0;
            inhint_reg <= 1'b0;
            iip_reg    <= 1'b0;
            nisql_reg  <= 1'b0;
            strtfc_reg <= 1'b1;
            rptfrc_reg <= 1'b0;
            ack_reg    <= '0;
            vec_reg    <= '0;
        end else begin
            sq_reg     <= sq_next;
            qc_reg     <= qc_next;
            sqr10_reg  <= sqr10_next;
            sqext_reg  <= sqext_next;
            futext_reg <= futext_next;
            inhint_reg <= inhint_next;
            iip_reg    <= iip_next;
            nisql_reg  <= nisql_next;
            strtfc_reg <= strtfc_next;
            rptfrc_reg <= rptfrc_next;
            ack_reg    <= ack_next;
            vec_reg    <= vec_next;
        end
    end

    // One-hot decode of {SQEXT,SQ} for the crosspoint logic.
    for (genvar gi = 0; gi < 2**(OPW+1); gi++) begin : g_opdec
        assign OPDEC[gi] = ({sqext_reg, sq_reg} == (OPW+1)'(gi));
    end

    assign SQ       = sq_reg;
    assign QC       = qc_reg;
    assign SQR10    = sqr10_reg;
    assign SQEXT    = sqext_reg;
    assign FUTEXT   = futext_reg;
    assign INHINT   = inhint_reg;
    assign IIP      = iip_reg;
    assign STRTFC   = strtfc_reg;
    assign RPTFRC   = rptfrc_reg;
    assign RUPT_ACK = ack_reg;
    assign RUPT_VEC = vec_reg;

endmodule
